// File: rtl/ddr2_line_bridge_pkg.sv
// Shared types and constants for the cache-line to DDR2 MIG user-interface bridge.
package ddr2_bridge_pkg;

    localparam int LINE_ADDR_W = 27;
    localparam int LINE_DATA_W = 128;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } bridge_state_t;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] addr;
        logic                   read;
        logic [LINE_DATA_W-1:0] data;
    } line_req_t;

    // The MIG sees whole 16-byte lines, so the byte offset is always cleared.
    function automatic logic [LINE_ADDR_W-1:0] line_align(input logic [LINE_ADDR_W-1:0] addr);
        return addr & {{(LINE_ADDR_W-4){1'b1}}, 4'b0000};
    endfunction

endpackage

// File: rtl/ddr2_line_bridge_if.sv
// Cache-side 128-bit line bus; the cache is the master, the bridge the slave.
interface ddr2_line_bridge_if;
    import ddr2_bridge_pkg::*;

    logic [LINE_ADDR_W-1:0] ddr2_addr;
    logic                   ddr2_enable;
    logic                   ddr2_read;
    logic [LINE_DATA_W-1:0] to_ddr2_data;
    logic [LINE_DATA_W-1:0] ddr2_data;
    logic                   ddr2_available;

    modport master (
        output ddr2_addr, ddr2_enable, ddr2_read, to_ddr2_data,
        input  ddr2_data, ddr2_available
    );

    modport slave (
        input  ddr2_addr, ddr2_enable, ddr2_read, to_ddr2_data,
        output ddr2_data, ddr2_available
    );

endinterface

// File: rtl/ddr2_line_bridge_req_fifo.sv
// Circular request queue of line_req_t; head is presented combinationally so the
// FSM can latch it on the same edge it pops.
module ddr2_req_fifo
    import ddr2_bridge_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  line_req_t i_push_data,
    input  logic      i_pop,
    output line_req_t o_head,
    output logic      o_full,
    output logic      o_empty,
    output logic      o_drop
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;
    line_req_t   r_mem [QDEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                       (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_pop     = i_pop && !w_empty;
    assign w_push_ok = i_push && (!w_full || w_pop);

    assign o_head  = r_mem[r_rd_ptr[PW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage has no reset; a full-and-popping push reuses the slot being read out.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/ddr2_line_bridge.sv
// Turns queued cache line requests into single-outstanding MIG app_* commands,
// handling the write-back then refill miss sequence in strict FIFO order.
module ddr2_line_bridge
    import ddr2_bridge_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    ddr2_line_bridge_if.slave        line,
    input  logic                     init_calib_complete,
    output logic [LINE_ADDR_W-1:0]   app_addr,
    output logic [2:0]               app_cmd,
    output logic                     app_en,
    input  logic                     app_rdy,
    output logic [LINE_DATA_W-1:0]   app_wdf_data,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    output logic [LINE_DATA_W/8-1:0] app_wdf_mask,
    input  logic                     app_wdf_rdy,
    input  logic [LINE_DATA_W-1:0]   app_rd_data,
    input  logic                     app_rd_data_valid,
    output logic                     busy,
    output logic                     overflow,
    output logic                     protocol_err
);

    bridge_state_t          r_state;
    logic [LINE_ADDR_W-1:0] r_app_addr;
    logic [2:0]             r_app_cmd;
    logic                   r_app_en;
    logic [LINE_DATA_W-1:0] r_wdf_data;
    logic                   r_wdf_wren;
    logic                   r_cmd_done;
    logic                   r_wdf_done;
    logic [LINE_DATA_W-1:0] r_ddr2_data;
    logic                   r_available;
    logic                   r_overflow;
    logic                   r_protocol_err;

    line_req_t w_push_req;
    line_req_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_drop;
    logic      w_pop;
    logic      w_cmd_hs;
    logic      w_wdf_hs;

    assign w_push_req = {line.ddr2_addr, line.ddr2_read, line.to_ddr2_data};
    assign w_pop      = (r_state == IDLE) && !w_empty && init_calib_complete;
    assign w_cmd_hs   = r_app_en && app_rdy;
    assign w_wdf_hs   = r_wdf_wren && app_wdf_rdy;

    ddr2_req_fifo #(
        .QDEPTH (QDEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (line.ddr2_enable),
        .i_push_data (w_push_req),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_drop      (w_drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_app_addr     <= '0;
            r_app_cmd      <= APP_CMD_WRITE;
            r_app_en       <= 1'b0;
            r_wdf_data     <= '0;
            r_wdf_wren     <= 1'b0;
            r_cmd_done     <= 1'b0;
            r_wdf_done     <= 1'b0;
            r_ddr2_data    <= '0;
            r_available    <= 1'b0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_available <= 1'b0;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (app_rd_data_valid && (r_state != RD_WAIT)) begin
                r_protocol_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_app_addr <= line_align(w_head.addr);
                        r_app_cmd  <= w_head.read ? APP_CMD_READ : APP_CMD_WRITE;
                        r_app_en   <= 1'b1;
                        r_cmd_done <= 1'b0;
                        // Reads have no data phase, so that side starts out finished.
                        r_wdf_done <= w_head.read;
                        r_wdf_wren <= !w_head.read;
                        if (!w_head.read) begin
                            r_wdf_data <= w_head.data;
                        end
                        r_state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (w_cmd_hs) begin
                        r_app_en   <= 1'b0;
                        r_cmd_done <= 1'b1;
                    end
                    if (w_wdf_hs) begin
                        r_wdf_wren <= 1'b0;
                        r_wdf_done <= 1'b1;
                    end
                    if (r_app_cmd == APP_CMD_READ) begin
                        if (w_cmd_hs) begin
                            r_state <= RD_WAIT;
                        end
                    end else if ((r_cmd_done || w_cmd_hs) && (r_wdf_done || w_wdf_hs)) begin
                        r_state <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (app_rd_data_valid) begin
                        r_ddr2_data <= app_rd_data;
                        r_available <= 1'b1;
                        r_state     <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign app_addr     = r_app_addr;
    assign app_cmd      = r_app_cmd;
    assign app_en       = r_app_en;
    assign app_wdf_data = r_wdf_data;
    assign app_wdf_wren = r_wdf_wren;
    assign app_wdf_end  = r_wdf_wren;
    assign app_wdf_mask = '0;

    assign line.ddr2_data      = r_ddr2_data;
    assign line.ddr2_available = r_available;

    assign busy         = !w_empty || (r_state != IDLE);
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;

endmodule
